// File: rtl/dcache_pkg.sv
// Shared types for the L1 data cache: address fields, line/word types and the
// memory-side FSM state encoding.
package dcache_pkg;

  localparam int N_LINES = 4;
  localparam int LINE_W  = 128;

  typedef logic [19:0]  pptr_t;
  typedef logic [13:0]  tag_t;
  typedef logic [1:0]   idx_t;
  typedef logic [3:0]   byte_offset_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;
  typedef logic [127:0] cacheline_t;
  typedef logic [15:0]  line_addr_t;

  typedef enum logic [1:0] {
    idle,
    wb,
    fill
  } dcache_state_t;

endpackage

// File: rtl/dcache_mem_fsm.sv
// Miss handler: sequences victim writeback and line fill over the req/ack
// memory port, holding the request registers stable until acknowledged.
module dcache_mem_fsm
  import dcache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         miss,
  input  logic         victim_dirty,
  input  logic [15:0]  victim_addr,
  input  logic [127:0] victim_line,
  input  logic [15:0]  req_line_addr,
  input  logic         mem_ack,
  output logic         in_idle,
  output logic         mem_req,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  output logic [127:0] mem_wdata,
  output logic         wb_done,
  output logic         fill_done
);

  dcache_state_t state_reg;
  line_addr_t    fill_addr_reg;
  logic          ack_seen;

  // An ack only counts while a request is actually outstanding.
  assign ack_seen  = mem_req && mem_ack;
  assign in_idle   = (state_reg == idle);
  assign wb_done   = (state_reg == wb) && ack_seen;
  assign fill_done = (state_reg == fill) && ack_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= idle;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      fill_addr_reg <= '0;
    end else begin
      case (state_reg)
        idle: begin
          mem_req <= 1'b0;
          if (miss) begin
            // Capture the fill address now so the fill survives req_valid dropping.
            fill_addr_reg <= req_line_addr;
            if (victim_dirty) begin
              state_reg <= wb;
              mem_we    <= 1'b1;
              mem_addr  <= victim_addr;
              mem_wdata <= victim_line;
            end else begin
              state_reg <= fill;
              mem_we    <= 1'b0;
              mem_addr  <= req_line_addr;
            end
          end
        end
        wb: begin
          if (ack_seen) begin
            state_reg <= fill;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= fill_addr_reg;
          end else begin
            mem_req <= 1'b1;
          end
        end
        fill: begin
          if (ack_seen) begin
            state_reg <= idle;
            mem_req   <= 1'b0;
          end else begin
            mem_req <= 1'b1;
          end
        end
        default: begin
          state_reg <= idle;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back/write-allocate L1 data cache: tag/data arrays, hit
// detection and store merge; misses are handed to dcache_mem_fsm.
module dcache
  import dcache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic         req_byte,
  input  logic [19:0]  req_addr,
  input  logic [31:0]  req_wdata,
  output logic [31:0]  rdata,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [127:0] mem_rdata
);

  cacheline_t         data_arr [N_LINES];
  tag_t               tag_arr  [N_LINES];
  logic [N_LINES-1:0] valid_reg, valid_next;
  logic [N_LINES-1:0] dirty_reg, dirty_next;

  tag_t         req_tag;
  idx_t         req_idx;
  byte_offset_t req_off;
  idx_t         fill_idx;
  tag_t         fill_tag;
  cacheline_t   hit_line, merged_line;
  logic         in_idle, wb_done, fill_done;
  logic         hit, miss, store_hit;

  assign req_tag  = req_addr[19:6];
  assign req_idx  = req_addr[5:4];
  assign req_off  = req_addr[3:0];
  // The outstanding transaction's own address names the line being replaced.
  assign fill_idx = mem_addr[1:0];
  assign fill_tag = mem_addr[15:2];
  assign hit_line = data_arr[req_idx];

  assign hit       = !rst && req_valid && in_idle && valid_reg[req_idx] && (tag_arr[req_idx] == req_tag);
  assign miss      = !rst && req_valid && in_idle && !hit;
  assign stall     = !rst && req_valid && !hit;
  assign store_hit = hit && req_we;

  always_comb begin
    merged_line = hit_line;
    if (req_byte)
      merged_line[{req_off, 3'b000} +: 8] = req_wdata[7:0];
    else
      merged_line[{req_off[3:2], 5'b00000} +: 32] = req_wdata;
  end

  always_comb begin
    rdata = '0;
    if (hit && !req_we) begin
      if (req_byte)
        rdata = {24'h0, hit_line[{req_off, 3'b000} +: 8]};
      else
        rdata = hit_line[{req_off[3:2], 5'b00000} +: 32];
    end
  end

  // Data and tags are never reset; only the valid/dirty bits are.
  always_ff @(posedge clk) begin
    if (!rst && store_hit) begin
      data_arr[req_idx] <= merged_line;
    end else if (!rst && fill_done) begin
      data_arr[fill_idx] <= mem_rdata;
      tag_arr[fill_idx]  <= fill_tag;
    end
  end

  for (genvar gi = 0; gi < N_LINES; gi++) begin : g_line_state
    assign valid_next[gi] = (fill_done && fill_idx == idx_t'(gi)) ? 1'b1 : valid_reg[gi];
    assign dirty_next[gi] = (store_hit && req_idx == idx_t'(gi)) ? 1'b1 :
                            ((wb_done || fill_done) && fill_idx == idx_t'(gi)) ? 1'b0 :
                            dirty_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      dirty_reg <= dirty_next;
    end
  end

  dcache_mem_fsm u_mem_fsm (
    .clk           (clk),
    .rst           (rst),
    .miss          (miss),
    .victim_dirty  (valid_reg[req_idx] && dirty_reg[req_idx]),
    .victim_addr   ({tag_arr[req_idx], req_idx}),
    .victim_line   (hit_line),
    .req_line_addr ({req_tag, req_idx}),
    .mem_ack       (mem_ack),
    .in_idle       (in_idle),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .wb_done       (wb_done),
    .fill_done     (fill_done)
  );

endmodule

// File: tb/tb_dcache.sv
// Directed and randomized bench for dcache against a byte-array cache model
// and a sparse main-memory model.
module tb_dcache;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_we, req_byte;
  logic [19:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [31:0]  rdata;
  logic         stall, mem_req, mem_we, mem_ack;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]   mline [4][16];
  logic [13:0]  mtag  [4];
  bit           mvalid[4];
  bit           mdirty[4];
  logic [127:0] mem_model [logic [15:0]];
  logic [16:0]  served [$];
  logic [31:0]  rd;

  dcache dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rdata     (rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [15:0] a);
    if (!mem_model.exists(a))
      mem_model[a] = {$urandom, $urandom, $urandom, $urandom};
    return mem_model[a];
  endfunction

  function automatic logic [127:0] model_line(input int i);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[b*8 +: 8] = mline[i][b];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
  endtask

  // Acts as main memory for one transaction; entered at negedge+1.
  task automatic serve(input bit we_exp, input logic [15:0] addr_exp,
                       input logic [127:0] wdata_exp, input int lat);
    int n = 0;
    logic [15:0] a0;
    while (mem_req !== 1'b1 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("mem_req_rise", mem_req, 1'b1);
    check("mem_we", mem_we, we_exp);
    check("mem_addr", mem_addr, addr_exp);
    if (we_exp) check("mem_wdata", mem_wdata, wdata_exp);
    served.push_back({mem_we, mem_addr});
    a0 = mem_addr;
    repeat (lat) begin
      @(negedge clk); #1;
      check("hold_req", mem_req, 1'b1);
      check("hold_addr", mem_addr, a0);
      check("hold_stall", stall, req_valid);
    end
    mem_ack = 1'b1;
    if (we_exp) mem_model[addr_exp] = wdata_exp;
    else        mem_rdata = mem_line(addr_exp);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("mem_req_drop", mem_req, 1'b0);
  endtask

  // One pipeline access, held until completed; leaves req_valid high.
  task automatic access(input bit we, input bit bw, input logic [19:0] addr,
                        input logic [31:0] wd, input int lat, output logic [31:0] rdo);
    logic [1:0]  idx;
    logic [13:0] tag;
    logic [3:0]  off, base;
    logic [31:0] exp;
    logic [127:0] line;
    int l;
    idx  = addr[5:4];
    tag  = addr[19:6];
    off  = addr[3:0];
    base = {off[3:2], 2'b00};
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = bw; req_addr = addr; req_wdata = wd;
    #1;
    if (!(mvalid[idx] && mtag[idx] == tag)) begin
      check("miss_stall", stall, 1'b1);
      if (mvalid[idx] && mdirty[idx]) begin
        l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        serve(1'b1, {mtag[idx], idx}, model_line(idx), l);
        mdirty[idx] = 1'b0;
      end
      l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      serve(1'b0, {tag, idx}, '0, l);
      line = mem_line({tag, idx});
      for (int b = 0; b < 16; b++) mline[idx][b] = line[b*8 +: 8];
      mtag[idx] = tag; mvalid[idx] = 1'b1; mdirty[idx] = 1'b0;
    end
    check("hit_stall", stall, 1'b0);
    check("hit_no_mem_req", mem_req, 1'b0);
    rdo = rdata;
    if (!we) begin
      if (bw) exp = {24'h0, mline[idx][off]};
      else    exp = {mline[idx][base+3], mline[idx][base+2], mline[idx][base+1], mline[idx][base]};
      check("load_data", rdata, exp);
    end
    @(posedge clk);
    if (we) begin
      if (bw) mline[idx][off] = wd[7:0];
      else for (int k = 0; k < 4; k++) mline[idx][base + 4'(k)] = wd[k*8 +: 8];
      mdirty[idx] = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("idle_stall", stall, 1'b0);
    check("idle_mem_req", mem_req, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Cold load of word 1 of a known line
    mem_model[16'h0012] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    served.delete();
    access(1'b0, 1'b0, 20'h00124, 32'h0, 3, rd);
    check("t1_rdata", rd, 32'hBBBBBBBB);
    check("t1_fill_only", served.size(), 1);
    check("t1_fill_addr", served[0], {1'b0, 16'h0012});

    // Store-byte hit followed immediately by a word load of the same line
    served.delete();
    access(1'b1, 1'b1, 20'h00123, 32'h0000005A, -1, rd);
    access(1'b0, 1'b0, 20'h00120, 32'h0, -1, rd);
    check("t2_rdata", rd, 32'h5AAAAAAA);
    check("t2_no_mem", served.size(), 0);
    idle_cycle();

    // Dirty eviction: make idx 2 tag 1 dirty, then load tag 2 idx 2
    access(1'b1, 1'b0, 20'h00060, 32'h12345678, -1, rd);
    idle_cycle();
    served.delete();
    access(1'b0, 1'b0, 20'h000A0, 32'h0, 2, rd);
    check("t3_txn_count", served.size(), 2);
    check("t3_wb_addr", served[0], {1'b1, 16'h0006});
    check("t3_fill_addr", served[1], {1'b0, 16'h000A});

    // Clean conflict: victim tag 2 is clean, so straight to fill
    served.delete();
    access(1'b0, 1'b0, 20'h00060, 32'h0, 1, rd);
    check("t4_rdata", rd, 32'h12345678);
    check("t4_fill_only", served.size(), 1);
    check("t4_fill_addr", served[0], {1'b0, 16'h0006});
    idle_cycle();

    // Reset while a fill is outstanding, then a late ack
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 20'h03000;
    n = 0;
    #1;
    while (mem_req !== 1'b1 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("t5_mem_req", mem_req, 1'b1);
    check("t5_mem_addr", mem_addr, 16'h0300);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check("t5_req_cleared", mem_req, 1'b0);
    check("t5_stall", stall, 1'b0);
    check("t5_addr_cleared", mem_addr, 16'h0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("t5_late_ack", mem_req, 1'b0);
    access(1'b0, 1'b0, 20'h03000, 32'h0, -1, rd);
    idle_cycle();

    // Long memory back-pressure
    access(1'b0, 1'b1, 20'h00407, 32'h0, 20, rd);
    idle_cycle();

    // Randomized traffic over a small tag set to force conflicts
    for (int i = 0; i < 150; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {14'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom)},
             $urandom, -1, rd);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
